instruction_fetch_unit: RTL and testbench

//  Program-counter and fetch stage sitting directly upstream of the instruction memory.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_queue.sv | 51 +++++
 rtl/instruction_fetch_unit.sv | 88 ++++++++
 tb/tb_instruction_fetch_unit.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM encoding,
// the {pc, instr} queue entry and the word-address helper.
package fetch_pkg;
  localparam int          INSTR_WIDTH = 32;
  localparam logic [31:0] PC_STEP     = 32'd4;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]            pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_addr(input logic [31:0] byte_pc);
    return {2'b00, byte_pc[31:2]};
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} entries with a flush that empties it
// in one edge. Simultaneous push and pop are legal even when full.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);
  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

  // Storage needs no reset: nothing is visible until cnt says so.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign head  = mem[rd_ptr];
endmodule

// File: rtl/instruction_fetch_unit.sv
// PC register, fetch FSM and redirect handling in front of a combinational
// instruction memory; fetched {pc, instr} pairs are queued for decode.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          QUEUE_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_enable,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        redirect_misalign
);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  fetch_state_e  state, state_nx;
  logic [31:0]   pc;
  logic          run, redir, push, pop;
  logic          q_full, q_empty;
  logic [CW-1:0] q_count;
  fetch_entry_t  q_head, q_din;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH_BOOT;
    else        state <= state_nx;
  end

  // Every state follows fetch_enable; BOOT just delays the first fetch by one edge.
  always_comb begin
    state_nx = state;
    run      = 1'b0;
    redir    = 1'b0;
    unique case (state)
      FETCH_BOOT: state_nx = fetch_enable ? FETCH_RUN : FETCH_HALT;
      FETCH_RUN: begin
        run      = 1'b1;
        redir    = redirect_valid;
        state_nx = fetch_enable ? FETCH_RUN : FETCH_HALT;
      end
      FETCH_HALT: begin
        redir    = redirect_valid;
        state_nx = fetch_enable ? FETCH_RUN : FETCH_HALT;
      end
      default: state_nx = FETCH_BOOT;
    endcase
  end

  assign pop   = out_valid & out_ready;
  assign push  = run & ~redirect_valid & (~q_full | pop);
  assign q_din = '{pc: pc, instr: imem_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc                <= RESET_VECTOR;
      redirect_misalign <= 1'b0;
    end else begin
      redirect_misalign <= redir & (|redirect_pc[1:0]);
      if (redir)     pc <= {redirect_pc[31:2], 2'b00};
      else if (push) pc <= pc + PC_STEP;
    end
  end

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .din   (q_din),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count),
    .head  (q_head)
  );

  assign imem_addr = word_addr(pc);
  assign out_valid = (q_count != '0);
  assign out_pc    = q_empty ? 32'h0 : q_head.pc;
  assign out_instr = q_empty ? 32'h0 : q_head.instr;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: streaming, backpressure, redirects,
// misalign pulse, PC wrap, halt and asynchronous reset mid-stream.
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        reset, fetch_enable, redirect_valid, out_ready;
  logic [31:0] redirect_pc, imem_addr, imem_data, out_instr, out_pc;
  logic        out_valid, redirect_misalign;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  // Memory model: word k holds 0x13 + 0x80*k (0x13, 0x93, ...).
  function automatic logic [31:0] mem_word(input logic [31:0] waddr);
    return {waddr[24:0], 7'h13};
  endfunction
  assign imem_data = mem_word(imem_addr);

  instruction_fetch_unit #(.RESET_VECTOR(32'h0), .QUEUE_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .fetch_enable(fetch_enable),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .redirect_misalign(redirect_misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Head of queue must carry the given byte PC and the matching memory word.
  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, ".pc"},    out_pc,             pc);
    chk({tag, ".instr"}, out_instr,          mem_word({2'b00, pc[31:2]}));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, ".pc"},    out_pc,             32'd0);
    chk({tag, ".instr"}, out_instr,          32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; fetch_enable = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    #1;
    chk_idle("rst");
    chk("rst.addr", imem_addr, 32'h0);
    chk("rst.mis", {31'b0, redirect_misalign}, 32'd0);
    step(); step();
    reset = 1'b1;

    // Streaming: BOOT edge, then one fetch per cycle
    step();
    chk_idle("boot");
    chk("boot.addr", imem_addr, 32'h0);
    step(); chk_head("s0", 32'h0); chk("s0.addr", imem_addr, 32'h1);
    step(); chk_head("s1", 32'h4);
    step(); chk_head("s2", 32'h8);

    // Stall until full, then reset asynchronously between edges
    out_ready = 1'b0;
    step(); chk_head("f0", 32'h8); chk("f0.addr", imem_addr, 32'h4);
    step(); chk_head("f1", 32'h8); chk("f1.addr", imem_addr, 32'h4);
    #2 reset = 1'b0;
    #1;
    chk_idle("arst");
    chk("arst.addr", imem_addr, 32'h0);
    step();
    reset = 1'b1;

    // Redirect during BOOT is ignored; keep out_ready low to fill queue
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    step();
    redirect_valid = 1'b0;
    chk("bootredir.addr", imem_addr, 32'h0);
    chk("bootredir.mis", {31'b0, redirect_misalign}, 32'd0);
    step(); chk_head("bp0", 32'h0);
    step(); chk_head("bp1", 32'h0); chk("bp1.addr", imem_addr, 32'h2);
    for (int i = 0; i < 3; i++) begin
      step(); chk_head("bphold", 32'h0); chk("bphold.addr", imem_addr, 32'h2);
    end
    out_ready = 1'b1;
    step(); chk_head("dr0", 32'h4);
    step(); chk_head("dr1", 32'h8);
    step(); chk_head("dr2", 32'hC);

    // Redirect while full: queue flushed, fetch resumes at target
    out_ready = 1'b0;
    step(); chk_head("full", 32'hC);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0; out_ready = 1'b1;
    chk_idle("rd");
    chk("rd.addr", imem_addr, 32'h10);
    chk("rd.mis", {31'b0, redirect_misalign}, 32'd0);
    step(); chk_head("rd1", 32'h40);

    // Misaligned target: one-cycle flag, fetch at aligned PC
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    step();
    redirect_valid = 1'b0;
    chk("mis.flag", {31'b0, redirect_misalign}, 32'd1);
    chk("mis.addr", imem_addr, 32'h10);
    chk_idle("mis");
    step();
    chk("mis.clr", {31'b0, redirect_misalign}, 32'd0);
    chk_head("mis1", 32'h40);

    // Back-to-back redirects: the last wins; then wrap at top of address space
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("wrap.addr", imem_addr, 32'h3FFF_FFFF);
    chk_idle("b2b");
    step(); chk_head("wrap0", 32'hFFFF_FFFC);
    step(); chk_head("wrap1", 32'h0);

    // Halt: the RUN edge still fetches, then nothing more; queue drains
    fetch_enable = 1'b0;
    step(); chk_head("halt0", 32'h4);
    step(); chk_idle("halt1"); chk("halt1.addr", imem_addr, 32'h2);
    step(); chk_idle("halt2"); chk("halt2.addr", imem_addr, 32'h2);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    chk("haltredir.addr", imem_addr, 32'h20);
    fetch_enable = 1'b1;
    step(); chk_idle("resume0");
    step(); chk_head("resume1", 32'h80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
